// File: rtl/score_digit_sequencer.sv
// -----------------------------------------------------------------------------
// score_digit_sequencer
//
// Purpose:
//   Producer side of the number-drawing interface. A binary value (score,
//   timer, lives) is converted to BCD with a sequential double-dabble on
//   load. The finished digits are committed atomically to a display register.
//   A registered per-pixel lookup then produces the draw request
//   (SEQ, X_OUT, Y_OUT, num) for one input port of the numbers mux.
//   Use one instance per on-screen number.
//
// Configuration:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits are not drawn.
//                           The last digit is always drawn.
//
// Ports:
//   clk          in   1        system clock
//   resetN       in   1        synchronous reset, active-low
//   value        in   VALUE_W  binary value, sampled on load
//   load         in   1        1-cycle request to convert and display value
//   pixelX       in   11       current VGA pixel X
//   pixelY       in   11       current VGA pixel Y
//   busy         out  1        conversion in progress (CONVERT or COMMIT)
//   done         out  1        1-cycle pulse when new digits become visible
//   SEQ          out  1        pixel inside this number's drawn digit area
//   X_OUT        out  11       X offset inside current digit cell
//   Y_OUT        out  11       Y offset inside current digit cell
//   num          out  4        BCD digit under current pixel
//   o_dbg_state  out  2        FSM state (0 IDLE, 1 CONVERT, 2 COMMIT)
//
// Handshake:
//   load is a single-cycle request with no ready. A load in IDLE starts a
//   conversion. A load while busy is held as pending, and the last such load
//   wins. done marks the cycle in which the display register is updated; the
//   new digits drive num from the following cycle on.
// -----------------------------------------------------------------------------
module score_digit_sequencer #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int DIGIT_W    = 16,
    parameter int DIGIT_H    = 32,
    parameter int TOP_LEFT_X = 0,
    parameter int TOP_LEFT_Y = 0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    output logic               busy,
    output logic               done,
    output logic               SEQ,
    output logic [10:0]        X_OUT,
    output logic [10:0]        Y_OUT,
    output logic [3:0]         num,
    output logic [1:0]         o_dbg_state
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int XS_W  = $clog2(DIGIT_W);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [VALUE_W-1:0]   r_shift;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     r_digits;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_pend_valid;
    logic [VALUE_W-1:0]   r_pend_val;
    logic [VALUE_W-1:0]   w_clamped;
    logic                 w_start;
    logic [VALUE_W-1:0]   w_start_val;

    // Values that cannot be shown in NUM_DIGITS decimal digits saturate to all nines.
    function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
        if (32'(v) > MAX_VAL)
            return MAX_VAL[VALUE_W-1:0];
        return v;
    endfunction

    assign w_clamped   = clamp_value(value);
    assign o_dbg_state = r_state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetN)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_start      = 1'b0;
        w_start_val  = w_clamped;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_start      = 1'b1;
                    w_next_state = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                if (r_bit_cnt == CNT_W'(VALUE_W - 1))
                    w_next_state = S_COMMIT;
            end
            S_COMMIT: begin
                busy = 1'b1;
                done = 1'b1;
                // A load arriving in COMMIT is newer than any held value, so it
                // replaces the pending value and is converted immediately.
                if (load || r_pend_valid) begin
                    w_start      = 1'b1;
                    w_start_val  = load ? w_clamped : r_pend_val;
                    w_next_state = S_CONVERT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Double-dabble: correct every nibble >= 5 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // ---------------- conversion datapath ----------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_shift      <= '0;
            r_bcd        <= '0;
            r_bit_cnt    <= '0;
            r_digits     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_val   <= '0;
        end else begin
            if (w_start) begin
                r_shift   <= w_start_val;
                r_bcd     <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == S_CONVERT) begin
                r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_shift[VALUE_W-1]};
                r_shift   <= {r_shift[VALUE_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state == S_COMMIT) begin
                r_digits     <= r_bcd;
                r_pend_valid <= 1'b0;
            end else if (r_state == S_CONVERT && load) begin
                r_pend_val   <= w_clamped;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // ---------------- pixel path ----------------
    // A 13-bit subtract keeps a borrow bit, so "left of / above origin" shows up
    // as a set MSB instead of a wrapped 11-bit offset.
    logic [12:0]         w_dx;
    logic [12:0]         w_dy;
    logic                w_inside;
    logic [10:0]         w_idx;
    logic [3:0]          w_num;
    logic                w_blank;
    logic [NUM_DIGITS-1:0] w_blank_vec;

    assign w_dx     = {2'b00, pixelX} - 13'(TOP_LEFT_X);
    assign w_dy     = {2'b00, pixelY} - 13'(TOP_LEFT_Y);
    assign w_inside = !w_dx[12] && (w_dx < 13'(NUM_DIGITS * DIGIT_W)) &&
                      !w_dy[12] && (w_dy < 13'(DIGIT_H));
    assign w_idx    = w_dx[10:0] >> XS_W;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is blank while it and every digit left of it are zero;
    // the rightmost digit is never blanked.
    always_comb begin
        logic lead_zero;
        lead_zero   = 1'b1;
        w_blank_vec = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lead_zero = lead_zero && (r_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            if (k < NUM_DIGITS - 1)
                w_blank_vec[k] = lead_zero;
        end
    end
`else
    assign w_blank_vec = '0;
`endif

    // Digit 0 is leftmost, held in the most significant nibble.
    always_comb begin
        w_num   = 4'd0;
        w_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx == 11'(k)) begin
                w_num   = r_digits[4*(NUM_DIGITS-1-k) +: 4];
                w_blank = w_blank_vec[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || !w_inside || w_blank) begin
            SEQ   <= 1'b0;
            X_OUT <= '0;
            Y_OUT <= '0;
            num   <= '0;
        end else begin
            SEQ   <= 1'b1;
            X_OUT <= w_dx[10:0] & 11'(DIGIT_W - 1);
            Y_OUT <= w_dy[10:0];
            num   <= w_num;
        end
    end

endmodule

// File: tb/tb_score_digit_sequencer.sv
module tb_score_digit_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic [13:0] value;
  logic        load;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        busy;
  logic        done;
  logic        SEQ;
  logic [10:0] X_OUT;
  logic [10:0] Y_OUT;
  logic [3:0]  num;
  logic [1:0]  o_dbg_state;

  score_digit_sequencer dut (
    .clk         (clk),
    .resetN      (resetN),
    .value       (value),
    .load        (load),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .busy        (busy),
    .done        (done),
    .SEQ         (SEQ),
    .X_OUT       (X_OUT),
    .Y_OUT       (Y_OUT),
    .num         (num),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int n_done   = 0;
  logic [13:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp9999(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pow10(3 - i)) % 10;
  endfunction

  // Drawn unless leading-zero blanking applies: digits 0..i all zero means v < 10**(3-i).
  function automatic logic drawn(input int v, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i < 3 && (v / pow10(3 - i)) == 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  // Queue holds [in-flight, pending]; a later load while busy overwrites the pending entry.
  task automatic sb_push(input int v);
    if (exp_q.size() < 2) exp_q.push_back(14'(v));
    else exp_q[1] = 14'(v);
  endtask

  task automatic do_load(input int v);
    @(posedge clk); #1;
    value = 14'(v);
    load  = 1'b1;
    sb_push(clamp9999(v));
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    @(posedge clk); #1;
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output logic [13:0] shown, output int at_cyc);
    bit found = 0;
    shown  = '0;
    at_cyc = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1;
    end
    if (!found) begin
      check("done_timeout", 0, 1);
    end else if (exp_q.size() == 0) begin
      check("unexpected_done", 1, 0);
    end else begin
      shown  = exp_q.pop_front();
      at_cyc = cyc;
    end
  endtask

  task automatic scan(input string tag, input int v);
    for (int i = 0; i < 4; i++) begin
      logic d;
      d = drawn(v, i);
      probe(i * 16 + 8, 5);
      check($sformatf("%s_seq%0d", tag, i), SEQ, d);
      check($sformatf("%s_num%0d", tag, i), num, d ? digit_of(v, i) : 0);
      check($sformatf("%s_x%0d", tag, i), X_OUT, d ? 8 : 0);
      check($sformatf("%s_y%0d", tag, i), Y_OUT, d ? 5 : 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [13:0] shown;
    int c1, c2, done_before, rv;

    resetN = 1'b0;
    value  = '0;
    load   = 1'b0;
    pixelX = '0;
    pixelY = '0;

    // 1: reset state, then pixel (0,0)
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seq", SEQ, 0);
    check("rst_state", o_dbg_state, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("p00_seq", SEQ, drawn(0, 0));
    check("p00_num", num, 0);
    check("p00_x", X_OUT, 0);
    check("p00_y", Y_OUT, 0);
    check("p00_busy", busy, 0);
    check("p00_done", done, 0);

    // 2: 1234 with exact busy/done timing (load in cycle 0)
    do_load(1234);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("t2_busy_c%0d", k), busy, (k >= 1 && k <= 15));
      check($sformatf("t2_done_c%0d", k), done, (k == 15));
    end
    shown = exp_q.pop_front();
    scan("t2", int'(shown));

    // 3: saturation and cell corners
    do_load(16383);
    wait_done(shown, c1);
    scan("t3", int'(shown));
    probe(63, 31);
    check("t3_corner_seq", SEQ, 1);
    check("t3_corner_num", num, 9);
    check("t3_corner_x", X_OUT, 15);
    check("t3_corner_y", Y_OUT, 31);
    probe(64, 0);
    check("t3_right_seq", SEQ, 0);
    check("t3_right_num", num, 0);
    check("t3_right_x", X_OUT, 0);
    probe(10, 32);
    check("t3_below_seq", SEQ, 0);
    check("t3_below_y", Y_OUT, 0);

    // 4: loads while busy; last pending wins, no idle gap between commits
    done_before = n_done;
    do_load(12);
    repeat (3) @(posedge clk);
    do_load(99);
    repeat (2) @(posedge clk);
    do_load(500);
    wait_done(shown, c1);
    check("t4_first_val", shown, 12);
    scan("t4a", int'(shown));
    wait_done(shown, c2);
    check("t4_second_val", shown, 500);
    check("t4_gap", c2 - c1, 15);
    scan("t4b", int'(shown));
    repeat (25) @(negedge clk);
    check("t4_done_count", n_done - done_before, 2);

    // 5: reset mid-conversion
    do_load(4321);
    repeat (5) @(posedge clk);
    #1 resetN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_state", o_dbg_state, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    exp_q.delete();
    done_before = n_done;
    repeat (30) @(negedge clk);
    check("t5_no_done", n_done - done_before, 0);
    scan("t5", 0);

    // 6: small values (blanking-sensitive) and random values
    do_load(7);
    wait_done(shown, c1);
    scan("t6_7", int'(shown));
    do_load(0);
    wait_done(shown, c1);
    scan("t6_0", int'(shown));
    for (int r = 0; r < 6; r++) begin
      rv = int'($urandom_range(0, 16383));
      do_load(rv);
      wait_done(shown, c1);
      scan($sformatf("rnd%0d", r), int'(shown));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
